truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 88 ++++++++
 tb/tb_truth_table_sweeper.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight vectors through a 3-input block and rebuilds its truth-table id.
// Optional TT_SWEEP_VERIFY_EN adds an expected/match compare of the result.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
`ifdef TT_SWEEP_VERIFY_EN
    input  logic [7:0] expected,
    output logic       match,
`endif
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [7:0] CNT_MAX = 8'(SETTLE);

    logic [1:0] state;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic [7:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            cnt         <= 8'd0;
            shreg       <= 8'd0;
            truth_table <= 8'd0;
            valid       <= 1'b0;
`ifdef TT_SWEEP_VERIFY_EN
            match       <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (start) begin
                        idx   <= 3'd0;
                        cnt   <= 8'd0;
                        valid <= 1'b0;
`ifdef TT_SWEEP_VERIFY_EN
                        match <= 1'b0;
`endif
                        state <= S_SETTLE;
                    end
                end
                (state == S_SETTLE): begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        // first vector ends up in the MSB after eight shifts
                        shreg <= {shreg[6:0], dut_out};
                        cnt   <= 8'd0;
                        if (idx == 3'd7) state <= S_COMMIT;
                        else             idx   <= idx + 3'd1;
                    end
                end
                (state == S_COMMIT): begin
                    truth_table <= shreg;
                    valid       <= 1'b1;
`ifdef TT_SWEEP_VERIFY_EN
                    match       <= (shreg == expected);
`endif
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SETTLE);
    assign done = (state == S_COMMIT);

    // idx keeps 7 after a sweep, so gate the vector outside SETTLE
    assign {in1, in2, in3} = busy ? idx : 3'b000;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE 4, 0, 2)
// each driving a table-driven 3-input gate model.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start [3];
    logic [7:0] gate  [3];
    logic       dut_out [3];
    logic       in1 [3];
    logic       in2 [3];
    logic       in3 [3];
    logic       busy [3];
    logic       done [3];
    logic [7:0] tt [3];
    logic       valid [3];
`ifdef TT_SWEEP_VERIFY_EN
    logic [7:0] expv [3];
    logic       match [3];
`endif

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 4 : (g == 1) ? 0 : 2;
        logic [2:0] vec;
        assign vec = {in1[g], in2[g], in3[g]};
        assign dut_out[g] = gate[g][3'd7 - vec];
        truth_table_sweeper #(.SETTLE(S)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start[g]),
            .dut_out(dut_out[g]),
`ifdef TT_SWEEP_VERIFY_EN
            .expected(expv[g]),
            .match(match[g]),
`endif
            .in1(in1[g]),
            .in2(in2[g]),
            .in3(in3[g]),
            .busy(busy[g]),
            .done(done[g]),
            .truth_table(tt[g]),
            .valid(valid[g])
        );
    end

    function automatic int settle_of(input int u);
        return (u == 0) ? 4 : (u == 1) ? 0 : 2;
    endfunction

    function automatic int sweep_len(input int u);
        return 8 * (settle_of(u) + 1);
    endfunction

    // Starts a sweep, returns edges from acceptance to done (or -1 on timeout).
    task automatic sweep(input int u, input logic [7:0] g, output int lat);
        gate[u]  = g;
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        lat = 0;
        while (done[u] !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 2000) lat = -1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in1[i], in2[i], in3[i], busy[i], done[i], valid[i]} !== 6'b0
                || tt[i] !== 8'h00) begin
                fails++;
                $display("FAIL reset u%0d: in=%b%b%b busy=%b done=%b valid=%b tt=%h, want all 0",
                         i, in1[i], in2[i], in3[i], busy[i], done[i], valid[i], tt[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || valid[i] !== 1'b0 || tt[i] !== 8'h00) begin
                fails++;
                $display("FAIL idle u%0d: busy=%b valid=%b tt=%h, want 0 0 00",
                         i, busy[i], valid[i], tt[i]);
            end
        end
    endtask

    task automatic run_and_check(input int u, input logic [7:0] g, input string nm);
        int lat;
        sweep(u, g, lat);
        checks++;
        if (lat != sweep_len(u)) begin
            fails++;
            $display("FAIL %s latency u%0d: got %0d, want %0d", nm, u, lat, sweep_len(u));
        end
        @(negedge clk);
        checks++;
        if (tt[u] !== g || valid[u] !== 1'b1 || done[u] !== 1'b0) begin
            fails++;
            $display("FAIL %s result u%0d: tt=%h valid=%b done=%b, want %h 1 0",
                     nm, u, tt[u], valid[u], done[u], g);
        end
    endtask

    task automatic test_gate_de();
`ifdef TT_SWEEP_VERIFY_EN
        expv[0] = 8'hDE;
`endif
        run_and_check(0, 8'hDE, "gate_de");
`ifdef TT_SWEEP_VERIFY_EN
        checks++;
        if (match[0] !== 1'b1) begin
            fails++;
            $display("FAIL match_hit: got %b, want 1", match[0]);
        end
        expv[0] = 8'hDF;
        run_and_check(0, 8'hDE, "gate_de2");
        checks++;
        if (match[0] !== 1'b0) begin
            fails++;
            $display("FAIL match_miss: got %b, want 0", match[0]);
        end
`endif
    endtask

    task automatic test_simple_gates();
        run_and_check(1, 8'h0F, "buf_in1");
        run_and_check(1, 8'h55, "buf_in3");
        run_and_check(1, 8'h00, "const0");
        run_and_check(1, 8'hFF, "const1");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int u;
            logic [7:0] g;
            u = n % 3;
            g = 8'($urandom_range(0, 255));
            run_and_check(u, g, "random");
        end
    endtask

    task automatic test_vector_order();
        logic [7:0] g;
        logic [2:0] want;
        logic [2:0] got;
        int bad;
        g = 8'($urandom_range(0, 255));
        gate[2]  = g;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        bad = 0;
        for (int k = 0; k <= 25; k++) begin
            want = (k < 24) ? 3'(k / 3) : 3'b000;
            got  = {in1[2], in2[2], in3[2]};
            if (got !== want || busy[2] !== (k < 24)) begin
                bad++;
                if (bad == 1)
                    $display("FAIL vector_order k=%0d: in=%b busy=%b, want %b %b",
                             k, got, busy[2], want, (k < 24));
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) fails++;
        checks++;
        if (tt[2] !== g || valid[2] !== 1'b1) begin
            fails++;
            $display("FAIL vector_order result: tt=%h valid=%b, want %h 1", tt[2], valid[2], g);
        end
    endtask

    task automatic test_start_held();
        int dones;
        gate[2]  = 8'hA5;
        start[2] = 1'b1;
        @(negedge clk);
        dones = 0;
        for (int k = 0; k <= 24; k++) begin
            if (done[2] === 1'b1) dones++;
            if (k < 24) @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            fails++;
            $display("FAIL start_held dones: got %0d, want 1", dones);
        end
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0 || valid[2] !== 1'b1 || tt[2] !== 8'hA5) begin
            fails++;
            $display("FAIL start_held idle: busy=%b valid=%b tt=%h, want 0 1 a5",
                     busy[2], valid[2], tt[2]);
        end
        @(negedge clk);
        start[2] = 1'b0;
        checks++;
        if (busy[2] !== 1'b1 || valid[2] !== 1'b0) begin
            fails++;
            $display("FAIL start_held restart: busy=%b valid=%b, want 1 0", busy[2], valid[2]);
        end
        for (int k = 0; k < 100 && done[2] !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (tt[2] !== 8'hA5 || valid[2] !== 1'b1) begin
            fails++;
            $display("FAIL start_held second: tt=%h valid=%b, want a5 1", tt[2], valid[2]);
        end
    endtask

    task automatic test_hold_during_sweep();
        int bad;
        int k;
        run_and_check(0, 8'hDE, "pre_hold");
        gate[0]  = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        bad = 0;
        k = 0;
        while (done[0] !== 1'b1 && k < 2000) begin
            if (tt[0] !== 8'hDE || valid[0] !== 1'b0) begin
                bad++;
                if (bad == 1)
                    $display("FAIL hold k=%0d: tt=%h valid=%b, want de 0", k, tt[0], valid[0]);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (bad != 0 || k != sweep_len(0)) begin
            fails++;
            $display("FAIL hold sweep: bad=%0d len=%0d, want 0 %0d", bad, k, sweep_len(0));
        end
        @(negedge clk);
        checks++;
        if (tt[0] !== 8'hFF || valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL hold commit: tt=%h valid=%b, want ff 1", tt[0], valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        run_and_check(0, 8'hDE, "pre_reset");
        gate[0]  = 8'h00;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in1[0], in2[0], in3[0], busy[0], done[0], valid[0]} !== 6'b0
            || tt[0] !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: in=%b%b%b busy=%b done=%b valid=%b tt=%h, want all 0",
                     in1[0], in2[0], in3[0], busy[0], done[0], valid[0], tt[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || tt[0] !== 8'h00 || valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid after: activity=%0d tt=%h valid=%b, want 0 00 0",
                     dones, tt[0], valid[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            gate[i]  = 8'h00;
`ifdef TT_SWEEP_VERIFY_EN
            expv[i]  = 8'h00;
`endif
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_gate_de();
        test_simple_gates();
        test_random();
        test_vector_order();
        test_start_held();
        test_hold_during_sweep();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
